hb5_feedback_decoder: RTL

//  Reads quadrature feedback (SA/SB Hall outputs) from one H-bridge motor Pmod
//  and returns it to the fabric as position, speed and direction. This is the

---
 rtl/hb5_feedback_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hb5_feedback_decoder.sv
// Quadrature Hall feedback decoder for one H-bridge motor Pmod: synchronizes and
// debounces SA/SB, then turns Gray-code transitions into position, direction and speed.
module hb5_feedback_decoder #(
  parameter int FILTER_LEN    = 4,
  parameter int WINDOW_CYCLES = 1000000,
  parameter int POS_W         = 32,
  parameter int SPD_W         = 16
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             sa,
  input  logic             sb,
  output logic [POS_W-1:0] position,
  output logic [SPD_W-1:0] speed,
  output logic             speed_valid,
  output logic             dir,
  output logic             err
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  // Forward rotation walks 00 -> 01 -> 11 -> 10 -> 00 on {sa,sb}.
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] v, input logic inc);
    logic [SPD_W-1:0] r;
    r = v;
    if (inc && (v != {SPD_W{1'b1}})) r = v + SPD_W'(1);
    return r;
  endfunction

  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       cand_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic [1:0]       filt_p2;
  logic [1:0]       prev_p3;
  logic             primed;
  logic [WIN_W-1:0] wcnt;
  logic [SPD_W-1:0] step_cnt;

  logic load;
  logic chg;
  logic fwd;
  logic rev;
  logic bad;
  logic step;

  always_comb begin
    load = 1'b0;
    chg  = 1'b0;
    fwd  = 1'b0;
    rev  = 1'b0;
    bad  = 1'b0;
    step = 1'b0;
    load = (sync_p1 == cand_p2) && (cnt_p2 == CNT_LAST);
    chg  = primed && (filt_p2 != prev_p3);
    fwd  = chg && (gray_next(prev_p3) == filt_p2);
    rev  = chg && (gray_next(filt_p2) == prev_p3);
    // Any other change flips both channels at once and has no direction.
    bad  = chg && !fwd && !rev;
    step = fwd || rev;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      cand_p2     <= '0;
      cnt_p2      <= '0;
      filt_p2     <= '0;
      prev_p3     <= '0;
      primed      <= 1'b0;
      position    <= '0;
      dir         <= 1'b0;
      err         <= 1'b0;
      wcnt        <= '0;
      step_cnt    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizer for the asynchronous Hall inputs
      sync_p0 <= {sa, sb};
      sync_p1 <= sync_p0;

      // p2: stability filter; cnt holds at its last value while the level stays put
      if (sync_p1 != cand_p2) begin
        cand_p2 <= sync_p1;
        cnt_p2  <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
        filt_p2 <= cand_p2;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end

      // p3: first accepted level only seeds prev; later changes are decoded
      if (!primed && load) begin
        prev_p3 <= cand_p2;
        primed  <= 1'b1;
      end
      err <= bad;
      if (fwd) begin
        position <= position + POS_W'(1);
        dir      <= 1'b1;
      end else if (rev) begin
        position <= position - POS_W'(1);
        dir      <= 1'b0;
      end
      if (chg) prev_p3 <= filt_p2;

      // Speed window: a step decoded on the final cycle still belongs to this window.
      if (wcnt == WIN_LAST) begin
        wcnt        <= '0;
        speed       <= sat_inc(step_cnt, step);
        speed_valid <= 1'b1;
        step_cnt    <= '0;
      end else begin
        wcnt        <= wcnt + WIN_W'(1);
        speed_valid <= 1'b0;
        step_cnt    <= sat_inc(step_cnt, step);
      end
    end
  end

endmodule
